// File: rtl/lstm_pkg.sv
// Shared constants for the LSTM input loader slice: data/address widths,
// frame geometry and the loader state encoding.
package lstm_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned ADDR_WIDTH  = 12;
  localparam int unsigned FRAC        = 24;
  localparam int unsigned TIMESTEP    = 7;
  localparam int unsigned LAYR1_INPUT = 53;
  localparam int unsigned FRAME_LEN   = TIMESTEP * LAYR1_INPUT;

  // Loader states
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_KICK = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/x_frame_ram.sv
// Simple dual-port frame RAM: one synchronous write port, one registered
// read-first read port. Out-of-range reads return 0, out-of-range writes drop.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : read port, 1-cycle latency
module x_frame_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 371
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    rdata_q;
  logic             w_in_range;
  logic             r_in_range;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;

  assign w_in_range = ({1'b0, waddr} < (AW+1)'(DEPTH));
  assign r_in_range = ({1'b0, raddr} < (AW+1)'(DEPTH));
  assign widx       = waddr[IDX_W-1:0];
  assign ridx       = raddr[IDX_W-1:0];

  // Storage array: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[widx] <= wdata;
    end
  end

  // Output register; nonblocking read of the old word gives read-first
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (r_in_range) begin
      rdata_q <= mem[ridx];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lstm_input_loader.sv
// Input loader for the LSTM core: captures one frame from a valid/ready
// stream into the frame RAM, pulses start, serves core reads while the core
// runs, and re-arms on the rising edge of finish.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_data/s_valid/s_last    : frame stream in, s_ready back-pressure out
//   addr_x1 / data_x1        : core read port, registered data
//   start / finish           : frame-ready pulse out, core-done level in
//   busy, err_len, frame_cnt : status (busy in KICK/RUN, sticky short frame,
//                              completed frame count)
module lstm_input_loader
  import lstm_pkg::*;
#(
  parameter int unsigned P_WIDTH       = WIDTH,
  parameter int unsigned P_ADDR_WIDTH  = ADDR_WIDTH,
  parameter int unsigned P_TIMESTEP    = TIMESTEP,
  parameter int unsigned P_LAYR1_INPUT = LAYR1_INPUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_WIDTH-1:0]      s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [P_ADDR_WIDTH-1:0] addr_x1,
  output logic [P_WIDTH-1:0]      data_x1,
  output logic                    start,
  input  logic                    finish,
  output logic                    busy,
  output logic                    err_len,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned FRAME_WORDS = P_TIMESTEP * P_LAYR1_INPUT;
  localparam logic [P_ADDR_WIDTH-1:0] LAST_PTR = P_ADDR_WIDTH'(FRAME_WORDS - 1);

  logic [1:0]              state_q,     state_d;
  logic [P_ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
  logic                    s_ready_q,   s_ready_d;
  logic                    start_q,     start_d;
  logic                    busy_q,      busy_d;
  logic                    err_len_q,   err_len_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    finish_q;
  logic                    accept_c;

  assign accept_c = s_valid & s_ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    err_len_d   = err_len_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (accept_c) begin
          if (wr_ptr_q == LAST_PTR) begin
            // Full frame; s_last on the final word is irrelevant
            state_d  = ST_KICK;
            wr_ptr_d = '0;
          end else if (s_last) begin
            // Short frame is dropped and loading restarts at word 0
            err_len_d = 1'b1;
            wr_ptr_d  = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + P_ADDR_WIDTH'(1);
          end
        end
      end
      ST_KICK: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Edge-triggered so a finish left high cannot release a later frame
        if (finish && !finish_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Outputs are decoded from the next state so they align with the state flop
    s_ready_d = (state_d == ST_LOAD);
    start_d   = (state_d == ST_KICK);
    busy_d    = (state_d == ST_KICK) || (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
      frame_cnt_q <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      s_ready_q   <= s_ready_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_len_q   <= err_len_d;
      frame_cnt_q <= frame_cnt_d;
      finish_q    <= finish;
    end
  end

  x_frame_ram #(
    .DW    (P_WIDTH),
    .AW    (P_ADDR_WIDTH),
    .DEPTH (FRAME_WORDS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept_c),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (addr_x1),
    .rdata (data_x1)
  );

  assign s_ready   = s_ready_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lstm_input_loader.sv
// Directed self-checking bench for lstm_input_loader.
module tb_lstm_input_loader;

  localparam int FLEN = 371;

  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [11:0] addr_x1;
  logic [31:0] data_x1;
  logic        start;
  logic        finish;
  logic        busy;
  logic        err_len;
  logic [15:0] frame_cnt;

  int tests;
  int fails;

  lstm_input_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .addr_x1   (addr_x1),
    .data_x1   (data_x1),
    .start     (start),
    .finish    (finish),
    .busy      (busy),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs and samples both sit 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n words (value base+index). Reports starts seen before the final
  // accept and whether the cycle budget ran out.
  task automatic send_frame(input int n, input int last_idx, input bit gaps,
                            input logic [31:0] base,
                            output int early_starts, output bit timed_out);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    early_starts = 0;
    timed_out = 1'b0;
    while (idx < n) begin
      if (start === 1'b1) early_starts++;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = s_valid ? base + 32'(idx) : 32'hBAD0_BAD0;
      s_last  = s_valid && (idx == last_idx);
      acc     = s_valid && s_ready;
      step();
      if (acc) idx++;
      cyc++;
      if (cyc > 5000) begin
        timed_out = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'h0;
  endtask

  task automatic read_check(input string name, input logic [11:0] a,
                            input logic [31:0] exp);
    addr_x1 = a;
    step();
    tests++;
    if (data_x1 !== exp) begin
      fails++;
      $display("FAIL %s: addr %0d data_x1=%h expected %h", name, a, data_x1, exp);
    end
  endtask

  task automatic pulse_finish(input logic [15:0] exp_cnt);
    finish = 1'b1;
    step();
    finish = 1'b0;
    tests++;
    if (frame_cnt !== exp_cnt || s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL finish_pulse: frame_cnt=%0d s_ready=%b busy=%b expected %0d/1/0",
               frame_cnt, s_ready, busy, exp_cnt);
    end
  endtask

  task automatic check_start(input string name, input int early, input bit to,
                             input logic exp_err);
    tests++;
    if (early != 0 || to || start !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1
        || err_len !== exp_err) begin
      fails++;
      $display("FAIL %s: early=%0d timeout=%b start=%b s_ready=%b busy=%b err_len=%b expected 0/0/1/0/1/%b",
               name, early, to, start, s_ready, busy, err_len, exp_err);
    end
    step();
    tests++;
    if (start !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_run: start=%b s_ready=%b busy=%b expected 0/0/1",
               name, start, s_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (s_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0
        || frame_cnt !== 16'd0 || data_x1 !== 32'd0) begin
      fails++;
      $display("FAIL reset: s_ready=%b start=%b busy=%b err_len=%b frame_cnt=%0d data_x1=%h expected all 0",
               s_ready, start, busy, err_len, frame_cnt, data_x1);
    end
    rst = 1'b0;
    step();
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: s_ready=%b busy=%b expected 1/0", s_ready, busy);
    end
    read_check("rd_oob_load", 12'd400, 32'd0);
  endtask

  task automatic test_full_frame();
    int e;
    bit to;
    send_frame(FLEN, -1, 1'b0, 32'h100, e, to);
    check_start("full_start", e, to, 1'b0);
    read_check("full_rd0", 12'd0, 32'h100);
    read_check("full_rd370", 12'd370, 32'h272);
    read_check("full_rd185", 12'd185, 32'h1B9);
    read_check("full_rd_oob", 12'd400, 32'd0);
  endtask

  task automatic test_run_blocks_stream();
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (s_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL run_block: cycle %0d s_ready=%b busy=%b expected 0/1", i, s_ready, busy);
      end
    end
    s_valid = 1'b0;
    s_data  = 32'h0;
    read_check("run_rd0", 12'd0, 32'h100);
    read_check("run_rd5", 12'd5, 32'h105);
    pulse_finish(16'd1);
  endtask

  task automatic test_early_last();
    int e;
    bit to;
    send_frame(100, 99, 1'b0, 32'h5000, e, to);
    tests++;
    if (e != 0 || to || start !== 1'b0 || err_len !== 1'b1 || s_ready !== 1'b1
        || busy !== 1'b0) begin
      fails++;
      $display("FAIL early_last: early=%0d timeout=%b start=%b err_len=%b s_ready=%b busy=%b expected 0/0/0/1/1/0",
               e, to, start, err_len, s_ready, busy);
    end
    send_frame(FLEN, -1, 1'b0, 32'h2000, e, to);
    check_start("after_short_start", e, to, 1'b1);
    read_check("after_short_rd0", 12'd0, 32'h2000);
    read_check("after_short_rd99", 12'd99, 32'h2063);
    read_check("after_short_rd370", 12'd370, 32'h2172);
    pulse_finish(16'd2);
  endtask

  task automatic test_gaps();
    int e;
    bit to;
    send_frame(FLEN, -1, 1'b1, 32'h3000, e, to);
    check_start("gap_start", e, to, 1'b1);
    read_check("gap_rd0", 12'd0, 32'h3000);
    read_check("gap_rd1", 12'd1, 32'h3001);
    read_check("gap_rd200", 12'd200, 32'h30C8);
    read_check("gap_rd370", 12'd370, 32'h3172);
    pulse_finish(16'd3);
  endtask

  task automatic test_finish_held();
    int e;
    bit to;
    logic [15:0] exp_cnt;
    exp_cnt = 16'd3;
    finish = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_frame(FLEN, -1, 1'b0, 32'h4000 + 32'(f * 32'h1000), e, to);
      check_start("held_start", e, to, 1'b1);
      for (int i = 0; i < 5; i++) step();
      tests++;
      if (busy !== 1'b1 || s_ready !== 1'b0 || frame_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL held_no_retrigger: frame %0d busy=%b s_ready=%b frame_cnt=%0d expected 1/0/%0d",
                 f, busy, s_ready, frame_cnt, exp_cnt);
      end
      finish = 1'b0;
      step();
      finish = 1'b1;
      step();
      exp_cnt = exp_cnt + 16'd1;
      tests++;
      if (frame_cnt !== exp_cnt || s_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL held_edge: frame %0d frame_cnt=%0d s_ready=%b busy=%b expected %0d/1/0",
                 f, frame_cnt, s_ready, busy, exp_cnt);
      end
    end
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (frame_cnt !== 16'd5) begin
      fails++;
      $display("FAIL held_settle: frame_cnt=%0d expected 5", frame_cnt);
    end
    finish = 1'b0;
    step();
  endtask

  task automatic test_reset_midload();
    int e;
    bit to;
    send_frame(200, -1, 1'b0, 32'h7000, e, to);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h7777;
    step();
    tests++;
    if (s_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0
        || frame_cnt !== 16'd0 || data_x1 !== 32'd0) begin
      fails++;
      $display("FAIL reset_midload: s_ready=%b start=%b busy=%b err_len=%b frame_cnt=%0d data_x1=%h expected all 0",
               s_ready, start, busy, err_len, frame_cnt, data_x1);
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    step();
    send_frame(FLEN, -1, 1'b0, 32'h6000, e, to);
    check_start("post_reset_start", e, to, 1'b0);
    read_check("post_reset_rd0", 12'd0, 32'h6000);
    read_check("post_reset_rd370", 12'd370, 32'h6172);
    read_check("post_reset_rd_oob", 12'd400, 32'd0);
    pulse_finish(16'd1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    s_data  = 32'h0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    addr_x1 = 12'd0;
    finish  = 1'b0;
    test_reset();
    test_full_frame();
    test_run_blocks_stream();
    test_early_last();
    test_gaps();
    test_finish_held();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lstm_input_loader.md
Name: lstm_input_loader

Overview:
Upstream feeder for the Zybo LSTM top level. It accepts one input frame (TIMESTEP × LAYR1_INPUT fixed-point words) over a valid/ready stream into a local frame RAM, then pulses start to the LSTM core. While the core runs, it serves data_x1 for the addr_x1 the core drives. On the core's finish it re-arms for the next frame.

Parameters:
WIDTH, 32, data word width (Q8.24 fixed point; FRAC=24 is not interpreted here)
ADDR_WIDTH, 12, frame RAM address width; matches the core's addr_x1
TIMESTEP, 7, timesteps per frame
LAYR1_INPUT, 53, input features per timestep
FRAME_LEN, TIMESTEP*LAYR1_INPUT (371), derived localparam, words per frame; must be ≤ 2^ADDR_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_data  in  WIDTH  stream input word
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts a word this cycle
s_last  in  1  marks the final word of a frame
addr_x1  in  ADDR_WIDTH  read address from the LSTM core
data_x1  out  WIDTH  frame word at addr_x1, registered
start  out  1  one-cycle pulse to the core: frame ready
finish  in  1  core done (level; rising edge is used)
busy  out  1  high in KICK and RUN
err_len  out  1  sticky: a frame was terminated early by s_last
frame_cnt  out  16  count of completed frames, wraps at 2^16

Behaviour:
- Reset values: s_ready=0, start=0, busy=0, err_len=0, frame_cnt=0, data_x1=0, wr_ptr=0, finish_q=0, state=LOAD. RAM contents are not cleared.
- Reset is synchronous and wins over every other event in the same cycle, including mid-load and mid-run. After reset, the loader sits in LOAD with wr_ptr=0.
- States:
  - LOAD: s_ready=1.
    - An accept is s_valid&s_ready. It writes mem[wr_ptr]=s_data and increments wr_ptr.
    - Accept with wr_ptr==FRAME_LEN-1: frame complete, go to KICK, wr_ptr←0. The value of s_last on this word is ignored.
    - Accept with s_last=1 and wr_ptr<FRAME_LEN-1: early end. Set err_len, set wr_ptr←0, stay in LOAD, no start. The partial frame is discarded.
  - KICK: s_ready=0, start=1 for exactly this cycle, busy=1. Go to RUN.
  - RUN: s_ready=0, busy=1. When finish & ~finish_q, frame_cnt←frame_cnt+1 and go to LOAD. s_ready is 1 the following cycle.
- finish_q is finish registered every cycle. Because RUN triggers only on the rising edge, a finish held high across frames never re-triggers.
- Read port:
  - Active every cycle regardless of state: data_x1 ← mem[addr_x1], 1-cycle latency.
  - addr_x1 ≥ FRAME_LEN gives data_x1=0.
  - A read and a write to the same address in the same cycle return the old data (read-first). The core only reads in RUN, so this case is harmless.
- Latency: the last accepted word is at cycle N; start is high at cycle N+1.
- err_len clears only on rst.

Decomposition:
- Shared package lstm_pkg:
  - FRAME_LEN localparam.
  - Loader state encoding (LOAD=0, KICK=1, RUN=2, 2-bit).
  - Width constants WIDTH, ADDR_WIDTH, FRAC.
- Sub-module x_frame_ram: simple dual-port RAM with a DEPTH parameter, one synchronous write port, and one registered read-first read port. It must infer BRAM on Zynq.
- FSM, write pointer, edge detect and counters live in lstm_input_loader.

Test Plan:
- Stream words 0..370 (value = index+0x100), s_valid held high → 371 accepts; start=1 exactly one cycle after the last accept; s_ready=0 from that cycle on; addr_x1=0 gives data_x1=0x100 next cycle; addr_x1=370 gives 0x272.
- s_last=1 on word index 99 → err_len=1, no start, wr_ptr back to 0. A following full 371-word frame then produces start; err_len stays 1.
- Random s_valid gaps (~50% duty) → exactly 371 accepts before start; no word is written during s_valid=0 cycles.
- During RUN, s_valid=1 with data 0xDEAD → s_ready=0 and RAM is unchanged. Pulse finish for 1 cycle → frame_cnt=1 and s_ready=1 on the next cycle.
- finish held high continuously across two full frames → each frame returns to LOAD only on a new rising edge; frame_cnt increments once per edge, never more.
- rst asserted after 200 accepts → all outputs at reset values. A new frame requires a full 371 accepts before start. Reading addr_x1=400 in any state returns 0.
